// File: rtl/conv_mac_0_pkg.sv
// Shared sizing constants and the ACC/HOLD state encoding for the conv_mac_* family.
// Defaults mirror the layer-0 sizes used by the weight streamer.
package conv_mac_0_pkg;

    localparam int COEFF_WIDTH     = 16;
    localparam int KERN_S_0        = 27;
    localparam int ACT_WIDTH       = 16;
    localparam int ACC_WIDTH       = 40;
    localparam int OUT_WIDTH       = 16;
    localparam int REQUANT_SHIFT_0 = 8;

    localparam int         MAC_STATE_W = 1;
    localparam logic [0:0] MAC_ST_ACC  = 1'b0;
    localparam logic [0:0] MAC_ST_HOLD = 1'b1;

    // A window of one product still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_mac_0_if.sv
// FIFO-side bundle for conv_mac_0: weight and activation read ports, result write port.
interface conv_mac_0_if
    import conv_mac_0_pkg::*;
#(
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int ACT_W   = ACT_WIDTH,
    parameter int OUT_W   = OUT_WIDTH
);
    // FIFO handshake: a pop happens on a rising edge where *_read=1 while *_empty_n=1
    // (data is *_dout before the edge); a push happens where output_V_write=1 while
    // output_V_full_n=1. Strobes are never raised when the matching flag is low.
    logic [COEFF_W-1:0] weight_V_dout;
    logic               weight_V_empty_n;
    logic               weight_V_read;
    logic [ACT_W-1:0]   input_V_dout;
    logic               input_V_empty_n;
    logic               input_V_read;
    logic [OUT_W-1:0]   output_V_din;
    logic               output_V_full_n;
    logic               output_V_write;

    modport master (
        input  weight_V_dout, weight_V_empty_n, input_V_dout, input_V_empty_n, output_V_full_n,
        output weight_V_read, input_V_read, output_V_din, output_V_write
    );

    modport slave (
        output weight_V_dout, weight_V_empty_n, input_V_dout, input_V_empty_n, output_V_full_n,
        input  weight_V_read, input_V_read, output_V_din, output_V_write
    );

endinterface

// File: rtl/conv_mac_0_requant_sat.sv
// Requantizer: arithmetic right shift (rounds toward -inf) then clamp to the signed OUT_W range.
module conv_mac_0_requant_sat #(
    parameter int ACC_W = 40,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_q
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_sh;

    assign w_sh = i_acc >>> SHIFT;

    always_comb begin
        o_q = w_sh[OUT_W-1:0];
        if (w_sh > MAX_V)
            o_q = MAX_V[OUT_W-1:0];
        else if (w_sh < MIN_V)
            o_q = MIN_V[OUT_W-1:0];
    end

endmodule

// File: rtl/conv_mac_0.sv
// Layer-0 MAC: pops weight/activation pairs in lockstep, accumulates KERN_S products,
// requantizes and holds the result until the output FIFO accepts it.
module conv_mac_0
    import conv_mac_0_pkg::*;
#(
    parameter int KERN_S  = KERN_S_0,
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int ACT_W   = ACT_WIDTH,
    parameter int ACC_W   = ACC_WIDTH,
    parameter int OUT_W   = OUT_WIDTH,
    parameter int SHIFT   = REQUANT_SHIFT_0
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    conv_mac_0_if.master           fifo,
    output logic [MAC_STATE_W-1:0] o_dbg_state
);

    localparam int CNT_W  = cnt_width(KERN_S);
    localparam int PROD_W = COEFF_W + ACT_W;

    logic [MAC_STATE_W-1:0]   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [OUT_W-1:0]         r_dout;

    logic                     w_fire;
    logic                     w_last;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [OUT_W-1:0]  w_q;

    // Strobes are gated by reset so nothing is popped or pushed while held in reset.
    assign w_fire = ap_rst_n && (r_state == MAC_ST_ACC) &&
                    fifo.weight_V_empty_n && fifo.input_V_empty_n;
    assign w_last = (r_cnt == CNT_W'(KERN_S - 1));

    assign w_prod = PROD_W'($signed(fifo.weight_V_dout)) * PROD_W'($signed(fifo.input_V_dout));
    assign w_sum  = ((r_cnt == '0) ? '0 : r_acc) + ACC_W'(w_prod);

    conv_mac_0_requant_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .i_acc (w_sum),
        .o_q   (w_q)
    );

    assign fifo.weight_V_read  = w_fire;
    assign fifo.input_V_read   = w_fire;
    assign fifo.output_V_write = ap_rst_n && (r_state == MAC_ST_HOLD) && fifo.output_V_full_n;
    assign fifo.output_V_din   = r_dout;
    assign o_dbg_state         = r_state;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= MAC_ST_ACC;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
        end else if (r_state == MAC_ST_ACC) begin
            if (w_fire) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_cnt   <= '0;
                    r_dout  <= w_q;
                    r_state <= MAC_ST_HOLD;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else if (fifo.output_V_full_n) begin
            r_state <= MAC_ST_ACC;
        end
    end

endmodule

// File: tb/tb_conv_mac_0.sv
// Bench for conv_mac_0: two instances (SHIFT=0 and SHIFT=8) share one stimulus stream
// and are checked every cycle against a window-level arithmetic model.
module tb_conv_mac_0;
  import conv_mac_0_pkg::*;

  localparam int K = 27;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;

  logic [15:0] w_dout = '0;
  logic        w_empty_n = 1'b0;
  logic [15:0] a_dout = '0;
  logic        a_empty_n = 1'b0;
  logic        full_n = 1'b0;

  logic [MAC_STATE_W-1:0] dbg0, dbg8;

  conv_mac_0_if if0 ();
  conv_mac_0_if if8 ();

  assign if0.weight_V_dout    = w_dout;
  assign if0.weight_V_empty_n = w_empty_n;
  assign if0.input_V_dout     = a_dout;
  assign if0.input_V_empty_n  = a_empty_n;
  assign if0.output_V_full_n  = full_n;
  assign if8.weight_V_dout    = w_dout;
  assign if8.weight_V_empty_n = w_empty_n;
  assign if8.input_V_dout     = a_dout;
  assign if8.input_V_empty_n  = a_empty_n;
  assign if8.output_V_full_n  = full_n;

  conv_mac_0 #(.KERN_S(K), .SHIFT(0)) dut0 (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .fifo        (if0),
    .o_dbg_state (dbg0)
  );

  conv_mac_0 #(.KERN_S(K), .SHIFT(8)) dut8 (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .fifo        (if8),
    .o_dbg_state (dbg8)
  );

  always #5 ap_clk = ~ap_clk;

  // Source FIFO contents and the behavioural model state.
  logic [15:0] wq[$];
  logic [15:0] aq[$];
  logic [15:0] exp0_q[$];
  logic [15:0] exp8_q[$];
  bit          pend;
  int          cnt;
  longint      sum;
  int          n_writes;
  logic [15:0] last0, last8;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] requant(input longint s, input int sh);
    longint q;
    q = s >>> sh;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic push_pair(input logic [15:0] w, input logic [15:0] a);
    wq.push_back(w);
    aq.push_back(a);
  endtask

  task automatic model_clear();
    wq.delete(); aq.delete(); exp0_q.delete(); exp8_q.delete();
    pend = 0; cnt = 0; sum = 0;
  endtask

  // One clock: present inputs, check strobes/data against the model, then advance the model.
  task automatic step(input int w_pct, input int a_pct, input bit full);
    bit rd_exp, wr_exp;
    @(negedge ap_clk);
    w_empty_n = (wq.size() > 0) && ($urandom_range(0, 99) < w_pct);
    a_empty_n = (aq.size() > 0) && ($urandom_range(0, 99) < a_pct);
    w_dout    = (wq.size() > 0) ? wq[0] : 16'h0;
    a_dout    = (aq.size() > 0) ? aq[0] : 16'h0;
    full_n    = full;
    #1;
    rd_exp = w_empty_n && a_empty_n && !pend;
    wr_exp = pend && full_n;
    n_checks++;
    if (if0.weight_V_read !== rd_exp || if0.input_V_read !== rd_exp ||
        if8.weight_V_read !== rd_exp || if8.input_V_read !== rd_exp) begin
      n_errors++;
      $display("FAIL rd_strobe t=%0t: got w0=%b a0=%b w8=%b a8=%b expected %b",
               $time, if0.weight_V_read, if0.input_V_read, if8.weight_V_read, if8.input_V_read, rd_exp);
    end
    n_checks++;
    if (if0.output_V_write !== wr_exp || if8.output_V_write !== wr_exp) begin
      n_errors++;
      $display("FAIL wr_strobe t=%0t: got dut0=%b dut8=%b expected %b",
               $time, if0.output_V_write, if8.output_V_write, wr_exp);
    end
    n_checks++;
    if (dbg0 !== (pend ? MAC_ST_HOLD : MAC_ST_ACC) || dbg8 !== (pend ? MAC_ST_HOLD : MAC_ST_ACC)) begin
      n_errors++;
      $display("FAIL dbg_state t=%0t: got %b/%b expected hold=%b", $time, dbg0, dbg8, pend);
    end
    if (pend) begin
      n_checks++;
      if (if0.output_V_din !== exp0_q[0] || if8.output_V_din !== exp8_q[0]) begin
        n_errors++;
        $display("FAIL din t=%0t: got dut0=%0d dut8=%0d expected %0d/%0d", $time,
                 $signed(if0.output_V_din), $signed(if8.output_V_din),
                 $signed(exp0_q[0]), $signed(exp8_q[0]));
      end
    end
    if (wr_exp) begin
      last0 = if0.output_V_din;
      last8 = if8.output_V_din;
    end
    @(posedge ap_clk);
    if (wr_exp) begin
      void'(exp0_q.pop_front());
      void'(exp8_q.pop_front());
      pend = 0;
      n_writes++;
    end
    if (rd_exp) begin
      sum += longint'($signed(wq.pop_front())) * longint'($signed(aq.pop_front()));
      cnt++;
      if (cnt == K) begin
        exp0_q.push_back(requant(sum, 0));
        exp8_q.push_back(requant(sum, 8));
        pend = 1; cnt = 0; sum = 0;
      end
    end
  endtask

  task automatic run_until_idle(input int w_pct, input int a_pct, input int budget, input string name);
    int n;
    n = 0;
    while ((wq.size() > 0 || pend) && n < budget) begin
      step(w_pct, a_pct, 1'b1);
      n++;
    end
    n_checks++;
    if (wq.size() > 0 || pend) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d pairs left pend=%b expected drained", name, wq.size(), pend);
    end
  endtask

  task automatic check_last(input string name, input logic [15:0] e0, input logic [15:0] e8);
    n_checks++;
    if (last0 !== e0 || last8 !== e8) begin
      n_errors++;
      $display("FAIL %s: got dut0=%0d dut8=%0d expected %0d/%0d", name,
               $signed(last0), $signed(last8), $signed(e0), $signed(e8));
    end
  endtask

  task automatic check_in_reset(input string name);
    n_checks++;
    if (if0.weight_V_read !== 1'b0 || if0.input_V_read !== 1'b0 || if0.output_V_write !== 1'b0 ||
        if8.weight_V_read !== 1'b0 || if8.input_V_read !== 1'b0 || if8.output_V_write !== 1'b0 ||
        if0.output_V_din !== 16'h0 || if8.output_V_din !== 16'h0 ||
        dbg0 !== MAC_ST_ACC || dbg8 !== MAC_ST_ACC) begin
      n_errors++;
      $display("FAIL %s: got rd=%b%b%b%b wr=%b%b din=%h/%h st=%b/%b expected all zero", name,
               if0.weight_V_read, if0.input_V_read, if8.weight_V_read, if8.input_V_read,
               if0.output_V_write, if8.output_V_write, if0.output_V_din, if8.output_V_din, dbg0, dbg8);
    end
  endtask

  task automatic test_reset();
    model_clear();
    w_dout = 16'd5; a_dout = 16'd7;
    w_empty_n = 1'b1; a_empty_n = 1'b1; full_n = 1'b1;
    #2;
    check_in_reset("reset_state");
    @(negedge ap_clk);
    w_empty_n = 1'b0; a_empty_n = 1'b0;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_unit_kernel();
    for (int i = 1; i <= K; i++) push_pair(16'd1, 16'(i));
    run_until_idle(100, 100, 100, "unit");
    check_last("unit_378", 16'd378, 16'd1);
  endtask

  task automatic test_signed_shift();
    for (int i = 0; i < K; i++) push_pair(-16'sd256, 16'sd3);
    run_until_idle(100, 100, 100, "signed");
    check_last("signed_neg81", 16'hAF00, 16'hFFAF);
    for (int i = 0; i < K; i++) push_pair(16'hFFFF, 16'd1);
    run_until_idle(100, 100, 100, "neg_one");
    check_last("shift_neg1", 16'hFFE5, 16'hFFFF);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < K; i++) push_pair(16'd32767, 16'd32767);
    run_until_idle(100, 100, 100, "sat_pos");
    check_last("sat_pos", 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < K; i++) push_pair(16'd32767, 16'h8000);
    run_until_idle(100, 100, 100, "sat_neg");
    check_last("sat_neg", 16'h8000, 16'h8000);
  endtask

  task automatic test_backpressure();
    int stall, w0, n;
    for (int i = 0; i < K; i++) push_pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    stall = 0; n = 0;
    w0 = n_writes;
    while ((wq.size() > 0 || pend) && n < 400) begin
      if (pend && stall < 10) begin
        step(50, 100, 1'b0);
        stall++;
      end else begin
        step(50, 100, 1'b1);
      end
      n++;
    end
    n_checks++;
    if (n_writes - w0 != 1 || stall != 10) begin
      n_errors++;
      $display("FAIL backpressure_writes: got %0d writes after %0d stall cycles expected 1 after 10",
               n_writes - w0, stall);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = n_writes;
    for (int i = 0; i < 4 * K; i++) push_pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 255)));
    run_until_idle(100, 100, 200, "b2b");
    n_checks++;
    if (n_writes - w0 != 4) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d results expected 4", n_writes - w0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < K; i++) push_pair(16'd100, 16'd100);
    n = 0;
    while (cnt < 10 && n < 100) begin
      step(100, 100, 1'b1);
      n++;
    end
    #3;
    ap_rst_n = 1'b0;
    #1;
    check_in_reset("reset_mid_async");
    @(negedge ap_clk);
    #1;
    check_in_reset("reset_mid_held");
    @(negedge ap_clk);
    model_clear();
    w_empty_n = 1'b0; a_empty_n = 1'b0;
    ap_rst_n = 1'b1;
    for (int i = 1; i <= K; i++) push_pair(16'd2, 16'(i));
    run_until_idle(100, 100, 100, "reset_mid");
    check_last("reset_mid_fresh", 16'd756, 16'd2);
  endtask

  initial begin
    n_writes = 0;
    last0 = '0; last8 = '0;
    test_reset();
    test_unit_kernel();
    test_signed_shift();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
